// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//   Staged reset release. A reset deassertion passes through a SYNC_STAGES-deep
//   synchronizer, then after HOLD_CYCLES edges domain 0 is released. Each later
//   domain is released GAP_CYCLES edges after the previous one.
//
//   Optional feature (macro RST_SEQ_SOFT_EN): a rising soft_req seen while the
//   sequencer is idle in RUN drops every domain and replays HOLD/RELEASE
//   without passing through the synchronizer again.
//
// Ports
//   clk        : single rising-edge clock
//   reset      : asynchronous active-low reset
//   soft_req   : synchronous soft-reset request (RST_SEQ_SOFT_EN only)
//   rst_n_out  : NUM_DOMAINS active-low resets, each driven straight from a flop
//   busy       : high while any rst_n_out bit is low
//   done       : high once every domain is released (always !busy)
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef RST_SEQ_SOFT_EN
    input  logic                   soft_req,
`endif
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // The edge on which ASSERT sees the synchronizer high is the first HOLD
    // edge, so the HOLD counter is loaded two short on that path.
    localparam logic       HOLD_ONE       = (HOLD_CYCLES == 1);
    localparam logic [7:0] HOLD_LOAD_SYNC = 8'((HOLD_CYCLES > 1) ? (HOLD_CYCLES - 2) : 0);
    localparam logic [7:0] GAP_LOAD       = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] LAST_IDX       = 4'(NUM_DOMAINS - 1);
`ifdef RST_SEQ_SOFT_EN
    // On a soft restart the lowering edge itself precedes the HOLD count.
    localparam logic [7:0] HOLD_LOAD_SOFT = 8'(HOLD_CYCLES - 1);
`endif

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_out_s;
    state_t                 state_r;
    logic [7:0]             cnt_r;
    logic [3:0]             idx_r;
    logic [NUM_DOMAINS-1:0] rst_n_out_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   rel_s;
    logic [NUM_DOMAINS-1:0] rel_mask_s;
`ifdef RST_SEQ_SOFT_EN
    logic                   soft_prev_r;
`endif

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign rst_n_out  = rst_n_out_r;
    assign busy       = busy_r;
    assign done       = done_r;

    // Reset-deassertion synchronizer; every stage clears asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

`ifdef RST_SEQ_SOFT_EN
    // Previous sampled soft_req, tracked in every state so a request held
    // high through a sequence cannot retrigger until it has been seen low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            soft_prev_r <= 1'b0;
        end else begin
            soft_prev_r <= soft_req;
        end
    end
`endif

    // Decide whether domain idx_r is released on this edge, and its bit mask.
    always_comb begin
        rel_s      = 1'b0;
        rel_mask_s = '0;
        case (state_r)
            ST_ASSERT:  rel_s = sync_out_s && HOLD_ONE;
            ST_HOLD:    rel_s = (cnt_r == 8'd0);
            ST_RELEASE: rel_s = (cnt_r == 8'd0);
            ST_RUN:     rel_s = 1'b0;
            default:    rel_s = 1'b0;
        endcase
        for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
            if (idx_r == 4'(i)) begin
                rel_mask_s[i] = 1'b1;
            end else begin
                rel_mask_s[i] = 1'b0;
            end
        end
    end

    // Sequencer FSM with registered reset outputs and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_ASSERT;
            cnt_r       <= 8'd0;
            idx_r       <= 4'd0;
            rst_n_out_r <= '0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else if (rel_s) begin
            rst_n_out_r <= rst_n_out_r | rel_mask_s;
            if (idx_r == LAST_IDX) begin
                state_r <= ST_RUN;
                cnt_r   <= 8'd0;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
            end else begin
                state_r <= ST_RELEASE;
                cnt_r   <= GAP_LOAD;
                idx_r   <= idx_r + 4'd1;
            end
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    if (sync_out_s) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= HOLD_LOAD_SYNC;
                    end
                end
                ST_HOLD, ST_RELEASE: begin
                    // Never wraps: a zero count releases instead of decrementing.
                    if (cnt_r != 8'd0) begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                ST_RUN: begin
`ifdef RST_SEQ_SOFT_EN
                    if (soft_req && !soft_prev_r) begin
                        state_r     <= ST_HOLD;
                        cnt_r       <= HOLD_LOAD_SOFT;
                        idx_r       <= 4'd0;
                        rst_n_out_r <= '0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_r     <= ST_ASSERT;
                    cnt_r       <= 8'd0;
                    idx_r       <= 4'd0;
                    rst_n_out_r <= '0;
                    busy_r      <= 1'b1;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
//   Three sequencer configurations share one clock, reset and soft_req. A
//   reference model derives each expected rst_n_out bit from the edge count
//   since the start of the current sequence:
//     bit k high  <=>  n >= base + HOLD + k*GAP
//   where base = SYNC_STAGES after a hard reset, or the soft-trigger edge.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

    localparam int P_N [3] = '{4, 1, 3};
    localparam int P_S [3] = '{2, 2, 3};
    localparam int P_H [3] = '{8, 1, 2};
    localparam int P_G [3] = '{4, 4, 1};
`ifdef RST_SEQ_SOFT_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       soft_req;
    logic [3:0] r0;
    logic [0:0] r1;
    logic [2:0] r2;
    logic       b0, b1, b2, d0, d1, d2;

    int total;
    int bad;
    int n;
    int base [3];
    bit prev [3];

    rst_sequencer #(.NUM_DOMAINS(4), .SYNC_STAGES(2), .HOLD_CYCLES(8), .GAP_CYCLES(4)) u_dut0 (
        .clk(clk), .reset(reset),
`ifdef RST_SEQ_SOFT_EN
        .soft_req(soft_req),
`endif
        .rst_n_out(r0), .busy(b0), .done(d0));

    rst_sequencer #(.NUM_DOMAINS(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(4)) u_dut1 (
        .clk(clk), .reset(reset),
`ifdef RST_SEQ_SOFT_EN
        .soft_req(soft_req),
`endif
        .rst_n_out(r1), .busy(b1), .done(d1));

    rst_sequencer #(.NUM_DOMAINS(3), .SYNC_STAGES(3), .HOLD_CYCLES(2), .GAP_CYCLES(1)) u_dut2 (
        .clk(clk), .reset(reset),
`ifdef RST_SEQ_SOFT_EN
        .soft_req(soft_req),
`endif
        .rst_n_out(r2), .busy(b2), .done(d2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expv(input int edge_n, input int b, input int i);
        logic [15:0] v;
        v = 16'd0;
        for (int k = 0; k < P_N[i]; k++) begin
            v[k] = (edge_n >= b + P_H[i] + k * P_G[i]);
        end
        return v;
    endfunction

    function automatic logic [15:0] full_mask(input int i);
        logic [15:0] v;
        v = 16'd0;
        for (int k = 0; k < P_N[i]; k++) begin
            v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic check_all();
        logic [31:0] got_r, got_b, got_d;
        logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                got_r = 32'(r0); got_b = 32'(b0); got_d = 32'(d0);
            end else if (i == 1) begin
                got_r = 32'(r1); got_b = 32'(b1); got_d = 32'(d1);
            end else begin
                got_r = 32'(r2); got_b = 32'(b2); got_d = 32'(d2);
            end
            e = reset ? expv(n, base[i], i) : 16'd0;
            chk($sformatf("dut%0d.rst_n_out", i), got_r, 32'(e));
            chk($sformatf("dut%0d.busy", i), got_b, 32'(e != full_mask(i)));
            chk($sformatf("dut%0d.done", i), got_d, 32'(e == full_mask(i)));
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            base[i] = P_S[i];
            prev[i] = 1'b0;
        end
    endtask

    // One clock edge: advance the model, then sample the DUTs 1ns later.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            n++;
            for (int i = 0; i < 3; i++) begin
                if (SOFT && (expv(n - 1, base[i], i) == full_mask(i)) && soft_req && !prev[i]) begin
                    base[i] = n;
                end
                prev[i] = soft_req;
            end
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int cnt);
        for (int c = 0; c < cnt; c++) begin
            step();
        end
    endtask

    // Hold reset low across 'cycles' edges, releasing 1ns after the last.
    task automatic long_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        steps(cycles);
        reset = 1'b1;
    endtask

    // Sub-period reset pulse placed between two clock edges.
    task automatic short_pulse();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        soft_req = 1'b0;
        reset    = 1'b1;
        model_reset();
        #1;

        // Power-on sequence with defaults: releases at edges 10/14/18/22.
        long_reset(3);
        steps(25);

        // Sub-period pulse while in RUN, then a full replay.
        short_pulse();
        steps(25);

        // Abort at edge 15, then restart timing from scratch.
        long_reset(2);
        steps(15);
        long_reset(1);
        steps(25);

        if (SOFT) begin
            // Soft request held high 20 cycles in RUN: exactly one replay.
            soft_req = 1'b1;
            steps(20);
            soft_req = 1'b0;
            steps(8);
            // Soft pulse at edge 12 while busy is ignored.
            long_reset(2);
            steps(11);
            soft_req = 1'b1;
            step();
            soft_req = 1'b0;
            steps(15);
        end

        // Randomized episodes: mixed reset styles and soft_req activity.
        for (int ep = 0; ep < 40; ep++) begin
            if ($urandom_range(0, 2) == 0) begin
                short_pulse();
            end else begin
                long_reset(int'($urandom_range(1, 3)));
            end
            for (int c = 0; c < int'($urandom_range(5, 50)); c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    soft_req = ~soft_req;
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
